result_framer: RTL and testbench

Sits directly downstream of the processor controller's egress port and its cycle-count output. Merges the processed byte stream and the measured clock-cycle count into one framed byte stream for the board's serial transmit path: header byte, payload bytes, 16-bit payload length, then the cycle count. The output stage is a single register, so every downstream byte is registered and fully back-pressurable.

---
 rtl/result_framer.sv | 151 +++++++++++++++
 tb/tb_result_framer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_framer.sv
// Frames a processed payload stream and its cycle count into one byte stream:
// header, payload, 16-bit little-endian length, then little-endian cycle count.
module result_framer #(
  parameter int          DATA_SIZE  = 8,
  parameter int          TIMER_SIZE = 32,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  last_in,
  input  logic [TIMER_SIZE-1:0] clock_cycles,
  input  logic                  clock_cycles_valid,
  output logic                  clock_cycles_ready,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  last_out
);

  localparam int NB    = TIMER_SIZE / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE, PAYLOAD, COUNT_LO, COUNT_HI, TIMER_WAIT, TIMER_BYTES
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TIMER_SIZE-1:0] shift_q, shift_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q, last_out_d;

  logic                  load_en;
  logic                  emit;
  logic [7:0]            emit_byte;
  logic                  emit_last;

  // The output register can take a new byte when empty or being drained.
  assign load_en = !valid_out_q || ready_out;

  always_comb begin
    state_d            = state_q;
    len_d              = len_q;
    idx_d              = idx_q;
    shift_d            = shift_q;
    ready_in           = 1'b0;
    clock_cycles_ready = 1'b0;
    emit               = 1'b0;
    emit_byte          = 8'h00;
    emit_last          = 1'b0;

    case (state_q)
      IDLE: begin
        // The triggering payload byte stays on the input; only the header goes out.
        if (valid_in && load_en) begin
          emit      = 1'b1;
          emit_byte = HEADER;
          len_d     = 16'h0000;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        ready_in = load_en;
        if (valid_in && load_en) begin
          emit      = 1'b1;
          emit_byte = data_in;
          len_d     = len_q + 16'd1;
          if (last_in) state_d = COUNT_LO;
        end
      end
      COUNT_LO: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_byte = len_q[7:0];
          state_d   = COUNT_HI;
        end
      end
      COUNT_HI: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_byte = len_q[15:8];
          state_d   = TIMER_WAIT;
        end
      end
      TIMER_WAIT: begin
        // Capture is independent of the output register so a stalled sink cannot block it.
        clock_cycles_ready = 1'b1;
        if (clock_cycles_valid) begin
          shift_d = clock_cycles;
          idx_d   = '0;
          state_d = TIMER_BYTES;
        end
      end
      TIMER_BYTES: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_byte = shift_q[7:0];
          shift_d   = shift_q >> 8;
          idx_d     = idx_q + 1'b1;
          if (idx_q == IDX_W'(NB - 1)) begin
            emit_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    if (emit) begin
      data_out_d  = emit_byte;
      valid_out_d = 1'b1;
      last_out_d  = emit_last;
    end else if (ready_out) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= 16'h0000;
      idx_q       <= '0;
      shift_q     <= '0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_result_framer.sv
// Directed bench for result_framer: framing, back-pressure, late count, reset, back-to-back.
module tb_result_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic [31:0] clock_cycles = 32'h0;
  logic        clock_cycles_valid = 1'b0;
  logic        clock_cycles_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          mode = 1'b0;
  int          cyc_cnt = 0;
  int          cc_hi_total = 0;
  int          base = 0;
  logic [8:0]  obs_q[$];
  int          obs_cyc[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  pay_mem[0:511];

  result_framer #(.DATA_SIZE(8), .TIMER_SIZE(32), .HEADER(8'hA5)) dut (
    .clock              (clock),
    .reset              (reset),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .ready_in           (ready_in),
    .last_in            (last_in),
    .clock_cycles       (clock_cycles),
    .clock_cycles_valid (clock_cycles_valid),
    .clock_cycles_ready (clock_cycles_ready),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .ready_out          (ready_out),
    .last_out           (last_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clock) begin
    #1;
    if (mode) ready_out = ~ready_out;
    else      ready_out = 1'b1;
  end

  always @(negedge clock) begin
    if (valid_out && ready_out) begin
      obs_q.push_back({last_out, data_out});
      obs_cyc.push_back(cyc_cnt);
    end
    if (clock_cycles_ready) cc_hi_total <= cc_hi_total + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic exp_frame(input int n, input logic [31:0] cyc);
    logic [15:0] len;
    len = 16'(n);
    exp_push(8'hA5, 1'b0);
    for (int i = 0; i < n; i++) exp_push(pay_mem[i], 1'b0);
    exp_push(len[7:0], 1'b0);
    exp_push(len[15:8], 1'b0);
    for (int b = 0; b < 4; b++) exp_push(cyc[8*b +: 8], b == 3);
  endtask

  task automatic run_frame(input int n, input logic [31:0] cyc, input int cc_delay);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    while (i < n && guard < 3000) begin
      @(posedge clock); #1;
      valid_in = 1'b1;
      data_in  = pay_mem[i];
      last_in  = (i == n - 1);
      @(negedge clock);
      if (ready_in) i++;
      guard++;
    end
    chk("payload_done", i, n);
    @(posedge clock); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    repeat (cc_delay) @(posedge clock);
    if (cc_delay > 5) begin
      @(negedge clock);
      chk("wait_vout", valid_out, 1'b0);
      chk("wait_ccrdy", clock_cycles_ready, 1'b1);
      @(posedge clock);
    end
    #1;
    clock_cycles       = cyc;
    clock_cycles_valid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 3000) begin
      @(negedge clock);
      if (clock_cycles_ready) acc = 1'b1;
      guard++;
    end
    chk("cc_accept", acc, 1'b1);
    @(posedge clock); #1;
    clock_cycles_valid = 1'b0;
  endtask

  task automatic check_obs(input string name);
    int guard;
    guard = 0;
    while (obs_q.size() - base < exp_q.size() && guard < 5000) begin
      @(posedge clock);
      guard++;
    end
    repeat (3) @(posedge clock);
    chk({name, "_count"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), obs_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    int cc0;
    #1 reset = 1'b0;
    #3;
    chk("rst_vout", valid_out, 1'b0);
    chk("rst_lout", last_out, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_rdyin", ready_in, 1'b0);
    chk("rst_ccrdy", clock_cycles_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Three-byte frame, sink always ready
    base = obs_q.size();
    pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33;
    exp_push(8'hA5, 0); exp_push(8'h11, 0); exp_push(8'h22, 0); exp_push(8'h33, 0);
    exp_push(8'h03, 0); exp_push(8'h00, 0); exp_push(8'h34, 0); exp_push(8'h12, 0);
    exp_push(8'h00, 0); exp_push(8'h00, 1);
    run_frame(3, 32'h0000_1234, 0);
    check_obs("t1");
    if (obs_q.size() >= base + 10)
      for (int k = 0; k < 9; k++)
        chk($sformatf("t1_gap%0d", k), obs_cyc[base + k + 1] - obs_cyc[base + k], (k == 5) ? 2 : 1);

    // Same frame with the sink toggling; check holds while stalled
    base = obs_q.size();
    mode = 1'b1;
    exp_push(8'hA5, 0); exp_push(8'h11, 0); exp_push(8'h22, 0); exp_push(8'h33, 0);
    exp_push(8'h03, 0); exp_push(8'h00, 0); exp_push(8'h34, 0); exp_push(8'h12, 0);
    exp_push(8'h00, 0); exp_push(8'h00, 1);
    fork
      run_frame(3, 32'h0000_1234, 0);
      begin
        bit         stalled;
        logic [7:0] held_d;
        logic       held_l;
        stalled = 1'b0;
        held_d  = 8'h00;
        held_l  = 1'b0;
        repeat (60) begin
          @(negedge clock);
          if (stalled) begin
            chk("t2_hold_data", data_out, held_d);
            chk("t2_hold_last", last_out, held_l);
            chk("t2_hold_vld", valid_out, 1'b1);
          end
          stalled = valid_out && !ready_out;
          held_d  = data_out;
          held_l  = last_out;
          if (stalled) chk("t2_rdyin_stall", ready_in, 1'b0);
        end
      end
    join
    check_obs("t2");
    mode = 1'b0;
    repeat (2) @(posedge clock);

    // Single payload byte; count handshake lasts one cycle
    base = obs_q.size();
    cc0 = cc_hi_total;
    pay_mem[0] = 8'h7E;
    exp_push(8'hA5, 0); exp_push(8'h7E, 0); exp_push(8'h01, 0); exp_push(8'h00, 0);
    exp_push(8'hEF, 0); exp_push(8'hBE, 0); exp_push(8'hAD, 0); exp_push(8'hDE, 1);
    run_frame(1, 32'hDEAD_BEEF, 0);
    check_obs("t3");
    chk("t3_ccrdy_cycles", cc_hi_total - cc0, 1);

    // Count arrives late; block idles in TIMER_WAIT
    base = obs_q.size();
    pay_mem[0] = 8'h01; pay_mem[1] = 8'h02;
    exp_frame(2, 32'h0BAD_CAFE);
    run_frame(2, 32'h0BAD_CAFE, 20);
    check_obs("t4");

    // Reset mid-payload, then a fresh frame
    @(posedge clock); #1;
    valid_in = 1'b1; data_in = 8'h01; last_in = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    data_in = 8'h02;
    @(posedge clock); #1;
    data_in = 8'h03;
    chk("t5_pre_data", data_out, 8'h02);
    chk("t5_pre_rdyin", ready_in, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_vout", valid_out, 1'b0);
    chk("t5_rst_lout", last_out, 1'b0);
    chk("t5_rst_rdyin", ready_in, 1'b0);
    valid_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    base = obs_q.size();
    pay_mem[0] = 8'h55;
    exp_push(8'hA5, 0); exp_push(8'h55, 0); exp_push(8'h01, 0); exp_push(8'h00, 0);
    exp_push(8'h0D, 0); exp_push(8'hF0, 0); exp_push(8'hFE, 0); exp_push(8'hCA, 1);
    run_frame(1, 32'hCAFE_F00D, 0);
    check_obs("t5");

    // Back-to-back frames with no bubble between them
    base = obs_q.size();
    pay_mem[0] = 8'h10;
    exp_frame(1, 32'h0000_0001);
    run_frame(1, 32'h0000_0001, 0);
    pay_mem[0] = 8'h20; pay_mem[1] = 8'h21;
    exp_frame(2, 32'h0000_0002);
    run_frame(2, 32'h0000_0002, 0);
    check_obs("t6");
    if (obs_q.size() >= base + 9)
      chk("t6_no_bubble", obs_cyc[base + 8] - obs_cyc[base + 7], 1);

    // Long payload: length field crosses a byte boundary
    base = obs_q.size();
    for (int i = 0; i < 300; i++) pay_mem[i] = 8'(i);
    exp_frame(300, 32'h1234_5678);
    run_frame(300, 32'h1234_5678, 0);
    if (obs_q.size() > base + 302) begin
      chk("t7_len_lo", obs_q[base + 301][7:0], 8'h2C);
      chk("t7_len_hi", obs_q[base + 302][7:0], 8'h01);
    end
    check_obs("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
